// File: rtl/layer_output_collector.sv
// layer_output_collector: captures each neuron's activation on its valid rising edge, then streams the layer out in index order.
// Define LAYER_ARGMAX_EN to add a signed argmax over every streamed layer (o_argmax/o_argmax_valid).
module layer_output_collector #(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH = 16,
  parameter int OUT_LATENCY = 1,
  parameter int LAYER_ID = 0,
  localparam int IW = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] i_act,
  input  logic [NUM_NEURONS-1:0]            i_act_valid,
  output logic [DATA_WIDTH-1:0]             o_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [IW-1:0]                     o_index,
  output logic                              o_last,
  output logic [31:0]                       o_layer_id,
  output logic                              o_overrun
`ifdef LAYER_ARGMAX_EN
  ,
  output logic [IW-1:0]                     o_argmax,
  output logic                              o_argmax_valid
`endif
);
  localparam int PL = OUT_LATENCY > 0 ? OUT_LATENCY : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_NEURONS - 1);
  typedef enum logic {s_COLLECT, s_STREAM} state_t;
  state_t state;
  logic [NUM_NEURONS-1:0] prev, captured, rise, start, cap;
  logic [NUM_NEURONS-1:0] pend [PL];
  logic [DATA_WIDTH-1:0] act_buf [NUM_NEURONS];
  logic accept, done;
  assign rise = i_act_valid & ~prev;
  // Rises seen while streaming are overruns and never enter the delay line.
  assign start = state == s_COLLECT ? rise : '0;
  assign cap = state != s_COLLECT ? '0 : OUT_LATENCY == 0 ? rise : pend[PL-1];
  assign accept = o_valid & i_ready;
  assign done = accept & o_last;
  assign o_data = act_buf[o_index];
  assign o_last = o_valid & (o_index == LAST);
  assign o_layer_id = 32'(LAYER_ID);
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= s_COLLECT;
      prev <= '1;
      captured <= '0;
      o_valid <= 1'b0;
      o_index <= '0;
      o_overrun <= 1'b0;
      for (int k = 0; k < NUM_NEURONS; k++) act_buf[k] <= '0;
      for (int j = 0; j < PL; j++) pend[j] <= '0;
    end else begin
      prev <= i_act_valid;
      pend[0] <= start;
      for (int j = 1; j < PL; j++) pend[j] <= pend[j-1];
      for (int k = 0; k < NUM_NEURONS; k++)
        if (cap[k]) act_buf[k] <= i_act[k*DATA_WIDTH +: DATA_WIDTH];
      if (state == s_STREAM && |rise) o_overrun <= 1'b1;
      if (state == s_COLLECT) begin
        captured <= captured | cap;
        if (&captured) begin
          state <= s_STREAM;
          o_valid <= 1'b1;
          o_index <= '0;
        end
      end else if (done) begin
        state <= s_COLLECT;
        o_valid <= 1'b0;
        o_index <= '0;
        captured <= '0;
      end else if (accept) o_index <= o_index + 1'b1;
    end
`ifdef LAYER_ARGMAX_EN
  logic [DATA_WIDTH-1:0] best;
  logic [IW-1:0] best_idx;
  logic take;
  // Strict compare so ties keep the lower index.
  assign take = o_index == '0 || $signed(o_data) > $signed(best);
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      best <= '0;
      best_idx <= '0;
      o_argmax <= '0;
      o_argmax_valid <= 1'b0;
    end else begin
      o_argmax_valid <= done;
      if (accept && take) begin
        best <= o_data;
        best_idx <= o_index;
      end
      if (done) o_argmax <= take ? o_index : best_idx;
    end
`endif
endmodule

// File: tb/tb_layer_output_collector.sv
// tb_layer_output_collector: directed stimulus against three collectors (N=4/L=1, N=4/L=0, N=1/L=1) with a per-cycle reference model.
module tb_layer_output_collector;
  localparam int N = 4;
  localparam int DW = 16;
  localparam int NI = 3;
  int lat [NI] = '{1, 0, 1};
  int nn [NI] = '{4, 4, 1};
  int lid [NI] = '{3, 3, 7};
  logic clk = 1'b0, rst_n = 1'b1, ready = 1'b0;
  logic [N*DW-1:0] act = '0;
  logic [N-1:0] av = '1;
  logic [DW-1:0] o_data [NI];
  logic [1:0] o_index [NI];
  logic o_valid [NI], o_last [NI], o_overrun [NI];
  logic [31:0] o_lid [NI];
  logic idx2;
`ifdef LAYER_ARGMAX_EN
  logic [1:0] o_am [NI];
  logic o_amv [NI];
  logic am2;
  assign o_am[2] = {1'b0, am2};
`endif
  assign o_index[2] = {1'b0, idx2};
  always #5 clk = ~clk;

  layer_output_collector #(.NUM_NEURONS(4), .DATA_WIDTH(DW), .OUT_LATENCY(1), .LAYER_ID(3)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_act(act), .i_act_valid(av), .o_data(o_data[0]), .o_valid(o_valid[0]),
    .i_ready(ready), .o_index(o_index[0]), .o_last(o_last[0]), .o_layer_id(o_lid[0]), .o_overrun(o_overrun[0])
`ifdef LAYER_ARGMAX_EN
    , .o_argmax(o_am[0]), .o_argmax_valid(o_amv[0])
`endif
  );
  layer_output_collector #(.NUM_NEURONS(4), .DATA_WIDTH(DW), .OUT_LATENCY(0), .LAYER_ID(3)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_act(act), .i_act_valid(av), .o_data(o_data[1]), .o_valid(o_valid[1]),
    .i_ready(ready), .o_index(o_index[1]), .o_last(o_last[1]), .o_layer_id(o_lid[1]), .o_overrun(o_overrun[1])
`ifdef LAYER_ARGMAX_EN
    , .o_argmax(o_am[1]), .o_argmax_valid(o_amv[1])
`endif
  );
  layer_output_collector #(.NUM_NEURONS(1), .DATA_WIDTH(DW), .OUT_LATENCY(1), .LAYER_ID(7)) dut1n (
    .i_clk(clk), .i_reset_n(rst_n), .i_act(act[DW-1:0]), .i_act_valid(av[0]), .o_data(o_data[2]), .o_valid(o_valid[2]),
    .i_ready(ready), .o_index(idx2), .o_last(o_last[2]), .o_layer_id(o_lid[2]), .o_overrun(o_overrun[2])
`ifdef LAYER_ARGMAX_EN
    , .o_argmax(am2), .o_argmax_valid(o_amv[2])
`endif
  );

  // Reference model: per-neuron capture due times, a streaming flag and an expected index.
  logic [DW-1:0] m_buf [NI][N];
  bit m_cap [NI][N], m_prev [NI][N];
  int due [NI][N];
  bit m_str [NI], m_ovr [NI], m_amv [NI];
  int m_idx [NI], m_am [NI];
  int cyc = 0;
  logic [DW-1:0] beats [NI][$];
  int vectors = 0, errors = 0;

  task automatic chk(string name, int i, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, got, exp, $time);
    end
  endtask

  task automatic step(int i);
    bit all = 1;
    bit any_rise = 0;
    int best = 0;
    for (int k = 0; k < nn[i]; k++) begin
      all &= m_cap[i][k];
      if (av[k] && !m_prev[i][k]) begin
        any_rise = 1;
        if (!m_str[i]) due[i][k] = cyc + lat[i];
      end
      m_prev[i][k] = av[k];
      if (due[i][k] == cyc) begin
        if (!m_str[i]) begin
          m_buf[i][k] = act[k*DW +: DW];
          m_cap[i][k] = 1;
        end
        due[i][k] = -1;
      end
    end
    m_amv[i] = 0;
    if (m_str[i] && any_rise) m_ovr[i] = 1;
    if (!m_str[i]) begin
      if (all) begin
        m_str[i] = 1;
        m_idx[i] = 0;
      end
    end else if (ready) begin
      if (m_idx[i] == nn[i] - 1) begin
        for (int k = 1; k < nn[i]; k++)
          if ($signed(m_buf[i][k]) > $signed(m_buf[i][best])) best = k;
        m_am[i] = best;
        m_amv[i] = 1;
        m_str[i] = 0;
        m_idx[i] = 0;
        for (int k = 0; k < N; k++) m_cap[i][k] = 0;
      end else m_idx[i]++;
    end
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_str[i] = 0; m_idx[i] = 0; m_ovr[i] = 0; m_am[i] = 0; m_amv[i] = 0;
        for (int k = 0; k < N; k++) begin
          m_buf[i][k] = '0; m_cap[i][k] = 0; m_prev[i][k] = 1; due[i][k] = -1;
        end
      end
    end else begin
      for (int i = 0; i < NI; i++) step(i);
      cyc++;
    end

  always @(posedge clk)
    for (int i = 0; i < NI; i++)
      if (o_valid[i] === 1'b1 && ready) beats[i].push_back(o_data[i]);

  always @(negedge clk)
    if (cyc > 0)
      for (int i = 0; i < NI; i++) begin
        chk("o_valid", i, 64'(o_valid[i]), 64'(m_str[i]));
        chk("o_overrun", i, 64'(o_overrun[i]), 64'(m_ovr[i]));
        chk("o_layer_id", i, 64'(o_lid[i]), 64'(lid[i]));
        if (m_str[i]) begin
          chk("o_data", i, 64'(o_data[i]), 64'(m_buf[i][m_idx[i]]));
          chk("o_index", i, 64'(o_index[i]), 64'(m_idx[i]));
          chk("o_last", i, 64'(o_last[i]), 64'(m_idx[i] == nn[i] - 1));
        end
`ifdef LAYER_ARGMAX_EN
        chk("o_argmax_valid", i, 64'(o_amv[i]), 64'(m_amv[i]));
        chk("o_argmax", i, 64'(o_am[i]), 64'(m_am[i]));
`endif
      end

  task automatic rise(int k, logic [DW-1:0] pre, logic [DW-1:0] v);
    av[k] = 1'b0;
    act[k*DW +: DW] = pre;
    @(negedge clk);
    av[k] = 1'b1;
    @(negedge clk);
    act[k*DW +: DW] = v;
    @(negedge clk);
  endtask

  task automatic load(logic [DW-1:0] v0, logic [DW-1:0] v1, logic [DW-1:0] v2, logic [DW-1:0] v3);
    rise(0, '0, v0);
    rise(1, '0, v1);
    rise(2, '0, v2);
    rise(3, '0, v3);
  endtask

  task automatic clear();
    for (int i = 0; i < NI; i++) beats[i].delete();
  endtask

  task automatic wait_beats(int i, int n);
    int c = 0;
    while (beats[i].size() < n && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk("beat_count", i, 64'(beats[i].size()), 64'(n));
  endtask

  task automatic wait_valid(int i);
    int c = 0;
    while (o_valid[i] !== 1'b1 && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk("wait_valid", i, 64'(o_valid[i]), 64'(1));
  endtask

  int bp [7] = '{0, 0, 1, 0, 1, 1, 1};

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 0, 64'(o_valid[0]), 64'(0));
    chk("rst_data", 0, 64'(o_data[0]), 64'(0));
    chk("rst_index", 0, 64'(o_index[0]), 64'(0));
    chk("rst_last", 0, 64'(o_last[0]), 64'(0));
    chk("rst_overrun", 0, 64'(o_overrun[0]), 64'(0));
    rst_n = 1'b1;
    // basic collect and stream
    ready = 1'b1;
    clear();
    load(16'h0010, 16'h7FFF, 16'h8000, 16'h0001);
    wait_beats(0, 4);
    wait_beats(1, 4);
    chk("basic_b0", 0, 64'(beats[0][0]), 64'h0010);
    chk("basic_b1", 0, 64'(beats[0][1]), 64'h7FFF);
    chk("basic_b2", 0, 64'(beats[0][2]), 64'h8000);
    chk("basic_b3", 0, 64'(beats[0][3]), 64'h0001);
    chk("single_count", 2, 64'(beats[2].size()), 64'(1));
    chk("single_b0", 2, 64'(beats[2][0]), 64'h0010);
    repeat (2) @(negedge clk);
    chk("basic_idle", 0, 64'(o_valid[0]), 64'(0));
    // backpressure
    ready = 1'b0;
    clear();
    load(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
    wait_valid(0);
    for (int j = 0; j < 7; j++) begin
      ready = bp[j][0];
      @(negedge clk);
      if (j == 1) chk("bp_hold_index", 0, 64'(o_index[0]), 64'(0));
      if (j == 3) chk("bp_hold_data", 0, 64'(o_data[0]), 64'h0B0B);
    end
    chk("bp_count", 0, 64'(beats[0].size()), 64'(4));
    chk("bp_b0", 0, 64'(beats[0][0]), 64'h0A0A);
    chk("bp_b3", 0, 64'(beats[0][3]), 64'h0D0D);
    chk("bp_idle", 0, 64'(o_valid[0]), 64'(0));
    ready = 1'b1;
    // capture latency
    clear();
    rise(0, 16'h1111, 16'h2222);
    rise(1, '0, 16'h0101);
    rise(2, '0, 16'h0202);
    rise(3, '0, 16'h0303);
    wait_beats(0, 4);
    wait_beats(1, 4);
    chk("lat1_b0", 0, 64'(beats[0][0]), 64'h2222);
    chk("lat0_b0", 1, 64'(beats[1][0]), 64'h1111);
    chk("lat0_b3", 1, 64'(beats[1][3]), 64'h0000);
    chk("single_lat", 2, 64'(beats[2][0]), 64'h2222);
    // overrun
    ready = 1'b0;
    clear();
    load(16'h0010, 16'h7FFF, 16'h8000, 16'h0001);
    wait_valid(0);
    chk("ovr_before", 0, 64'(o_overrun[0]), 64'(0));
    rise(2, 16'h5555, 16'h6666);
    ready = 1'b1;
    wait_beats(0, 4);
    chk("ovr_set", 0, 64'(o_overrun[0]), 64'(1));
    chk("ovr_b2", 0, 64'(beats[0][2]), 64'h8000);
    repeat (4) @(negedge clk);
    chk("ovr_sticky", 0, 64'(o_overrun[0]), 64'(1));
    // reset mid-stream
    ready = 1'b0;
    clear();
    load(16'h0021, 16'h0022, 16'h0023, 16'h0024);
    wait_valid(0);
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_index", 0, 64'(o_index[0]), 64'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 0, 64'(o_valid[0]), 64'(0));
    chk("async_overrun", 0, 64'(o_overrun[0]), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("no_spurious", 0, 64'(o_valid[0]), 64'(0));
    chk("no_spurious", 1, 64'(o_valid[1]), 64'(0));
    chk("no_spurious", 2, 64'(o_valid[2]), 64'(0));
    // signed values, argmax when enabled
    clear();
    load(16'd5, 16'hFFFD, 16'd9, 16'd9);
    wait_beats(0, 4);
`ifdef LAYER_ARGMAX_EN
    chk("argmax_pulse", 0, 64'(o_amv[0]), 64'(1));
    chk("argmax", 0, 64'(o_am[0]), 64'(2));
    @(negedge clk);
    chk("argmax_pulse_end", 0, 64'(o_amv[0]), 64'(0));
    chk("argmax_hold", 0, 64'(o_am[0]), 64'(2));
`endif
    chk("signed_b1", 0, 64'(beats[0][1]), 64'hFFFD);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
